// File: rtl/csr_trap_seq.sv
// Trap / mret sequencer: snapshots the request, writes mepc/mcause/mtval/mstatus
// through the single CSR write port one per cycle, then pulses a fetch redirect.
module csr_trap_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            mret_ready,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [1:0]      csr_mode,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            mode_we,
  output logic [1:0]      mode_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [2:0]      state_dbg
);

  // Handshakes: a request transfers on the rising edge where valid & ready are
  // both high; ready never depends on a lower-priority valid, and a requester
  // held off keeps valid asserted until it transfers. The redirect has no ready.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_TVAL   = 3'd3,
    T_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIR    = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, cause_q, tval_q, mstatus_q, mtvec_q, mepc_q;
  logic [1:0]      mode_q;
  logic            is_mret_q;

  logic [XLEN-1:0] trap_status, mret_status, tvec_base, trap_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mode_q    <= '0;
      is_mret_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (trap_valid) begin
        pc_q      <= trap_pc;
        cause_q   <= trap_cause;
        tval_q    <= trap_tval;
        mstatus_q <= csr_mstatus;
        mtvec_q   <= csr_mtvec;
        mode_q    <= csr_mode;
        is_mret_q <= 1'b0;
      end else if (mret_valid) begin
        mstatus_q <= csr_mstatus;
        mepc_q    <= csr_mepc;
        is_mret_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trap_valid)      state_d = T_EPC;
        else if (mret_valid) state_d = M_STATUS;
      end
      T_EPC:    state_d = T_CAUSE;
      T_CAUSE:  state_d = T_TVAL;
      T_TVAL:   state_d = T_STATUS;
      T_STATUS: state_d = REDIR;
      M_STATUS: state_d = REDIR;
      REDIR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // mstatus rewrites and trap vector, all from the snapshots taken at accept.
  always_comb begin
    trap_status        = mstatus_q;
    trap_status[7]     = mstatus_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = mode_q;
    mret_status        = mstatus_q;
    mret_status[3]     = mstatus_q[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b00;
    tvec_base          = mtvec_q & {{(XLEN-2){1'b1}}, 2'b00};
    trap_target        = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
      trap_target = tvec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
  end

  always_comb begin
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    wr_ready       = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    mode_we        = 1'b0;
    mode_wdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        trap_ready = 1'b1;
        mret_ready = !trap_valid;
        wr_ready   = !trap_valid && !mret_valid;
        if (wr_valid && !trap_valid && !mret_valid) begin
          csr_we    = 1'b1;
          csr_waddr = wr_addr;
          csr_wdata = wr_data;
        end
      end
      T_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = pc_q;
      end
      T_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = cause_q;
      end
      T_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h343;
        csr_wdata = tval_q;
      end
      T_STATUS: begin
        csr_we     = 1'b1;
        csr_waddr  = 12'h300;
        csr_wdata  = trap_status;
        mode_we    = 1'b1;
        mode_wdata = 2'b11;
      end
      M_STATUS: begin
        csr_we     = 1'b1;
        csr_waddr  = 12'h300;
        csr_wdata  = mret_status;
        mode_we    = 1'b1;
        mode_wdata = mstatus_q[12:11];
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_mret_q ? mepc_q : trap_target;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
